// File: rtl/picomips_mc.sv
// picomips_mc: multi-cycle picoMIPS core (FETCH/EXEC/HALT) with an input handshake and an output strobe.
// Define PICOMIPS_MULH_EN to make opcode 9 an unsigned multiply-high; without it, opcode 9 is a NOP.
module picomips_mc #(
  parameter int unsigned N     = 8,
  parameter int unsigned RADDR = 3,
  parameter int unsigned PSIZE = 5,
  parameter int unsigned ISIZE = 4 + 2 * RADDR + N
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PSIZE-1:0] prog_addr,
  input  logic [ISIZE-1:0] prog_data,
  input  logic [N-1:0]     sw_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     display,
  output logic             out_valid,
  output logic             halted
);

  localparam int unsigned NREG = 2 ** RADDR;

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpAddi = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpSubi = 4'd4;
  localparam logic [3:0] OpAnd  = 4'd5;
  localparam logic [3:0] OpOr   = 4'd6;
  localparam logic [3:0] OpXor  = 4'd7;
  localparam logic [3:0] OpLdi  = 4'd8;
  localparam logic [3:0] OpMulh = 4'd9;
  localparam logic [3:0] OpBeq  = 4'd10;
  localparam logic [3:0] OpBne  = 4'd11;
  localparam logic [3:0] OpJmp  = 4'd12;
  localparam logic [3:0] OpIn   = 4'd13;
  localparam logic [3:0] OpOut  = 4'd14;
  localparam logic [3:0] OpHalt = 4'd15;

`ifdef PICOMIPS_MULH_EN
  localparam int unsigned W2 = 2 * N;
`endif

  logic [1:0]       state_q, state_d;
  logic [PSIZE-1:0] pc_q, pc_d;
  logic             z_q, z_d;
  logic [N-1:0]     display_q, display_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     regs_q [NREG];

  logic [3:0]       op;
  logic [RADDR-1:0] rd, rs;
  logic [N-1:0]     imm, rd_val, rs_val;
  logic [N-1:0]     alu_res, wr_data;
  logic             alu_upd, wr_en;
  logic [PSIZE-1:0] pc_inc, target;

  assign op     = prog_data[ISIZE-1 -: 4];
  assign rd     = prog_data[N+2*RADDR-1 -: RADDR];
  assign rs     = prog_data[N+RADDR-1 -: RADDR];
  assign imm    = prog_data[N-1:0];
  assign rd_val = (rd == '0) ? '0 : regs_q[rd];
  assign rs_val = (rs == '0) ? '0 : regs_q[rs];
  assign pc_inc = pc_q + PSIZE'(1);
  assign target = imm[PSIZE-1:0];

  assign prog_addr = pc_q;
  assign display   = display_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == StHalt);
  assign in_ready  = (state_q == StExec) && (op == OpIn);

  // ALU ops; alu_upd marks the ones that write rd and update Z.
  always_comb begin
    alu_res = '0;
    alu_upd = 1'b0;
    case (op)
      OpAdd:  begin alu_res = rd_val + rs_val; alu_upd = 1'b1; end
      OpAddi: begin alu_res = rd_val + imm;    alu_upd = 1'b1; end
      OpSub:  begin alu_res = rd_val - rs_val; alu_upd = 1'b1; end
      OpSubi: begin alu_res = rd_val - imm;    alu_upd = 1'b1; end
      OpAnd:  begin alu_res = rd_val & rs_val; alu_upd = 1'b1; end
      OpOr:   begin alu_res = rd_val | rs_val; alu_upd = 1'b1; end
      OpXor:  begin alu_res = rd_val ^ rs_val; alu_upd = 1'b1; end
`ifdef PICOMIPS_MULH_EN
      OpMulh: begin
        alu_res = N'((W2'(rd_val) * W2'(rs_val)) >> N);
        alu_upd = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    z_d         = z_q;
    display_d   = display_q;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_data     = alu_res;
    case (state_q)
      StFetch: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        if (alu_upd) begin
          wr_en = 1'b1;
          z_d   = (alu_res == '0);
        end
        case (op)
          OpNop: ;
          OpLdi: begin wr_en = 1'b1; wr_data = imm; end
          OpBeq: if (z_q)  pc_d = target;
          OpBne: if (!z_q) pc_d = target;
          OpJmp: pc_d = target;
          OpIn: begin
            if (in_valid) begin
              wr_en   = 1'b1;
              wr_data = sw_data;
            end else begin
              // Stall: nothing changes until the handshake completes.
              state_d = StExec;
              pc_d    = pc_q;
            end
          end
          OpOut: begin
            display_d   = rd_val;
            out_valid_d = 1'b1;
          end
          OpHalt: begin
            state_d = StHalt;
            pc_d    = pc_q;
          end
`ifndef PICOMIPS_MULH_EN
          OpMulh: ;
`endif
          default: ;
        endcase
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      z_q         <= 1'b0;
      display_q   <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      z_q         <= z_d;
      display_q   <= display_d;
      out_valid_q <= out_valid_d;
      if (wr_en && (rd != '0)) begin
        regs_q[rd] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_picomips_mc.sv
// Directed bench for picomips_mc: small programs in a one-cycle-latency ROM, checked at known edges.
module tb_picomips_mc;

  logic        clk;
  logic        reset;
  logic [4:0]  prog_addr;
  logic [17:0] prog_data;
  logic [7:0]  sw_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  display;
  logic        out_valid;
  logic        halted;

  logic [17:0] rom [32];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int pulse_cnt, pulse_edge, halt_edge, ready_cnt;
  logic [7:0] mulh_exp;

  picomips_mc dut (
    .clk       (clk),
    .reset     (reset),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .sw_data   (sw_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .display   (display),
    .out_valid (out_valid),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];

  // Edge counter: edge 1 is the first rising edge after reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      pulse_cnt  = 0;
      pulse_edge = 0;
      halt_edge  = 0;
      ready_cnt  = 0;
    end else begin
      if (out_valid) begin
        pulse_cnt++;
        pulse_edge = cyc;
      end
      if (halted && halt_edge == 0) halt_edge = cyc;
      if (in_ready) ready_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ins(input logic [3:0] op, input int rd, input int rs,
                                      input int imm);
    return {op, 3'(rd), 3'(rs), 8'(imm)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Return just after the falling edge that follows rising edge n.
  task automatic wait_edge(input int n);
    int guard = 0;
    while (cyc < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got edge %0d, expected edge %0d", cyc, n);
    end
    #1;
  endtask

  initial begin
`ifdef PICOMIPS_MULH_EN
    mulh_exp = 8'h4E;
`else
    mulh_exp = 8'd200;
`endif
    reset    = 1'b0;
    in_valid = 1'b0;
    sw_data  = 8'h3C;
    clear_rom();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst prog_addr", 32'(prog_addr), 0);
    check_eq("rst display", 32'(display), 0);
    check_eq("rst out_valid", 32'(out_valid), 0);
    check_eq("rst in_ready", 32'(in_ready), 0);
    check_eq("rst halted", 32'(halted), 0);

    // Basic sequence
    clear_rom();
    rom[0] = ins(4'd8, 1, 0, 5);
    rom[1] = ins(4'd8, 2, 0, 3);
    rom[2] = ins(4'd1, 1, 2, 0);
    rom[3] = ins(4'd14, 1, 0, 0);
    rom[4] = ins(4'd15, 0, 0, 0);
    apply_reset();
    wait_edge(14);
    check_eq("basic display", 32'(display), 8);
    check_eq("basic pulses", 32'(pulse_cnt), 1);
    check_eq("basic pulse edge", 32'(pulse_edge), 8);
    check_eq("basic halt edge", 32'(halt_edge), 10);
    check_eq("basic halted", 32'(halted), 1);
    check_eq("basic prog_addr", 32'(prog_addr), 4);

    // Counted loop
    clear_rom();
    rom[0] = ins(4'd8, 1, 0, 3);
    rom[1] = ins(4'd4, 1, 0, 1);
    rom[2] = ins(4'd11, 0, 0, 1);
    rom[3] = ins(4'd14, 1, 0, 0);
    rom[4] = ins(4'd15, 0, 0, 0);
    apply_reset();
    wait_edge(22);
    check_eq("loop display", 32'(display), 0);
    check_eq("loop pulses", 32'(pulse_cnt), 1);
    check_eq("loop pulse edge", 32'(pulse_edge), 16);
    check_eq("loop halt edge", 32'(halt_edge), 18);

    // Input handshake: 5 stalled EXEC cycles, transfer at edge 7
    clear_rom();
    rom[0] = ins(4'd13, 3, 0, 0);
    rom[1] = ins(4'd14, 3, 0, 0);
    rom[2] = ins(4'd15, 0, 0, 0);
    apply_reset();
    wait_edge(3);
    check_eq("in ready mid-wait", 32'(in_ready), 1);
    check_eq("in prog_addr held", 32'(prog_addr), 0);
    wait_edge(6);
    in_valid = 1'b1;
    sw_data  = 8'hA5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sw_data = 8'h3C;
    wait_edge(12);
    check_eq("in ready cycles", 32'(ready_cnt), 6);
    check_eq("in display", 32'(display), 8'hA5);
    check_eq("in pulse edge", 32'(pulse_edge), 9);
    check_eq("in ready after halt", 32'(in_ready), 0);

    // r0 and PC wrap-around
    clear_rom();
    rom[0]  = ins(4'd8, 0, 0, 7);
    rom[1]  = ins(4'd14, 0, 0, 0);
    rom[2]  = ins(4'd12, 0, 0, 31);
    rom[31] = ins(4'd0, 0, 0, 0);
    apply_reset();
    wait_edge(6);
    check_eq("jmp prog_addr", 32'(prog_addr), 31);
    wait_edge(8);
    check_eq("wrap prog_addr", 32'(prog_addr), 0);
    check_eq("r0 display", 32'(display), 0);
    check_eq("r0 pulse edge", 32'(pulse_edge), 4);

    // Z flag: OR clears Z, XOR sets it, LDI leaves it alone
    clear_rom();
    rom[0] = ins(4'd8, 1, 0, 8'h0F);
    rom[1] = ins(4'd8, 2, 0, 8'hF0);
    rom[2] = ins(4'd6, 1, 2, 0);
    rom[3] = ins(4'd10, 0, 0, 9);
    rom[4] = ins(4'd7, 1, 1, 0);
    rom[5] = ins(4'd10, 0, 0, 7);
    rom[6] = ins(4'd14, 2, 0, 0);
    rom[7] = ins(4'd3, 3, 2, 0);
    rom[8] = ins(4'd14, 3, 0, 0);
    rom[9] = ins(4'd15, 0, 0, 0);
    apply_reset();
    wait_edge(20);
    check_eq("zflag display", 32'(display), 8'h10);
    check_eq("zflag pulses", 32'(pulse_cnt), 1);
    check_eq("zflag pulse edge", 32'(pulse_edge), 16);
    check_eq("zflag halt edge", 32'(halt_edge), 18);

    // MULH
    clear_rom();
    rom[0] = ins(4'd8, 1, 0, 200);
    rom[1] = ins(4'd8, 2, 0, 100);
    rom[2] = ins(4'd9, 1, 2, 0);
    rom[3] = ins(4'd14, 1, 0, 0);
    rom[4] = ins(4'd15, 0, 0, 0);
    apply_reset();
    wait_edge(12);
    check_eq("mulh display", 32'(display), 32'(mulh_exp));

    // Reset during an IN wait
    clear_rom();
    rom[0] = ins(4'd8, 1, 0, 9);
    rom[1] = ins(4'd14, 1, 0, 0);
    rom[2] = ins(4'd13, 3, 0, 0);
    rom[3] = ins(4'd14, 3, 0, 0);
    rom[4] = ins(4'd15, 0, 0, 0);
    apply_reset();
    wait_edge(7);
    check_eq("rw in_ready before", 32'(in_ready), 1);
    check_eq("rw display before", 32'(display), 9);
    reset = 1'b0;
    #1;
    check_eq("rw in_ready", 32'(in_ready), 0);
    check_eq("rw prog_addr", 32'(prog_addr), 0);
    check_eq("rw display", 32'(display), 0);
    check_eq("rw halted", 32'(halted), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_edge(2);
    check_eq("rw restart prog_addr", 32'(prog_addr), 1);
    wait_edge(4);
    check_eq("rw restart display", 32'(display), 9);
    check_eq("rw restart pulse edge", 32'(pulse_edge), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/picomips_mc.md
# picomips_mc

Parametrised multi-cycle successor to the single-cycle picoMIPS core. Adds a scalable register file, conditional branching on a zero flag, a valid/ready input handshake, a registered output strobe and a halt state. Fetches from an external synchronous program ROM. Sits at the top of the processor hierarchy, between the program ROM, the switch input and the display.

## Interface
- `N`, default 8: data width.
- `RADDR`, default 3: register address bits; the register file holds 2^RADDR registers.
- `PSIZE`, default 5: program address bits.
- `ISIZE`, default `4+2*RADDR+N`: instruction width. Derived; do not override.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `prog_addr` output, PSIZE bits: ROM address; always equals the PC register.
- `prog_data` input, ISIZE bits: ROM word for the `prog_addr` of the previous cycle.
- `sw_data` input, N bits: input data.
- `in_valid` input, 1 bit: `sw_data` is valid.
- `in_ready` output, 1 bit: core accepts input this cycle.
- `display` output, N bits: registered output value.
- `out_valid` output, 1 bit: one-cycle strobe; `display` was updated on this edge.
- `halted` output, 1 bit: core is in HALT.

## Operation
- Instruction fields, MSB first: `op[3:0]`, `rd[RADDR]`, `rs[RADDR]`, `imm[N]`.
- r0 reads as 0; writes to r0 are discarded.
- Opcodes:
  - 0 NOP
  - 1 ADD: rd=rd+rs
  - 2 ADDI: rd=rd+imm
  - 3 SUB: rd=rd-rs
  - 4 SUBI: rd=rd-imm
  - 5 AND, 6 OR, 7 XOR: rd=rd op rs
  - 8 LDI: rd=imm
  - 9 MULH: see Configuration
  - 10 BEQ: branch if Z
  - 11 BNE: branch if !Z
  - 12 JMP
  - 13 IN: rd=sw_data
  - 14 OUT: display=rd
  - 15 HALT
- Arithmetic is modulo 2^N; carry is discarded.
- Z flag: set to (result==0) by opcodes 1-7 and 9 (when enabled) only. It resets to 0.
- Branch/JMP target is `imm[PSIZE-1:0]`. Otherwise the next PC is `(pc+1) mod 2^PSIZE`, wrapping 2^PSIZE-1 to 0.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: `prog_addr`=pc. Always goes to EXEC next.
  - EXEC: decode `prog_data`. Write rd, Z, PC and display at the exiting edge, then return to FETCH.
  - EXEC with IN and `in_valid`=0: hold in EXEC with no state change, PC held.
  - EXEC with HALT: go to HALT with PC unchanged.
  - HALT: absorbing until reset. `halted`=1; no writes, no strobes.
- `in_ready` is combinational: 1 iff state=EXEC and op=IN. Transfer occurs on the edge where `in_valid`&&`in_ready`. `sw_data` is sampled at that edge.
- OUT: `display`<=rd and `out_valid`<=1 at the EXEC exit edge. `out_valid` is 1 for exactly one cycle.
- Reset (any state, including mid-IN wait) immediately clears:
  - state=FETCH and pc=0
  - all registers and Z to 0
  - `display`=0, `out_valid`=0, `halted`=0
  - `in_ready` drops to 0 combinationally.

## Timing
- Reset values of all outputs: `prog_addr`=0, `display`=0, `out_valid`=0, `in_ready`=0, `halted`=0.
- Each instruction takes 2 cycles (FETCH+EXEC). IN takes 2 cycles plus the number of wait cycles.
- After reset is released, instruction k (0-based, no waits) commits at rising edge 2k+2.
- ROM latency is exactly one cycle; `prog_addr` is stable throughout FETCH and EXEC.
- A register written by instruction k is visible to instruction k+1. No hazards exist.
- A taken branch costs no extra cycles.

## Configuration
- Macro `PICOMIPS_MULH_EN`.
- Defined: opcode 9 computes rd = upper N bits of the unsigned 2N-bit product rd*rs, and updates Z.
- Undefined: opcode 9 executes as NOP, leaving rd and Z unchanged. No multiplier is synthesised.

## Test plan
- Basic sequence: LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; HALT -> `display`=8 with a single `out_valid` pulse at edge 8; `halted`=1 from edge 10; `prog_addr` stays 4.
- Counted loop: 0:LDI r1,3; 1:SUBI r1,1; 2:BNE 1; 3:OUT r1; 4:HALT -> BNE is taken twice; `display`=0; exactly one `out_valid` pulse.
- Input handshake: IN r3 with `in_valid` held low for 5 cycles, then pulsed with `sw_data`=0xA5; then OUT r3 -> `in_ready` is high for all 6 EXEC cycles; `display`=0xA5.
- r0 and wrap-around: LDI r0,7; OUT r0 -> `display`=0. Then JMP 31, with a NOP at address 31 -> next `prog_addr`=0.
- MULH: LDI r1,200; LDI r2,100; MULH r1,r2; OUT r1 -> `display`=0x4E with the macro defined, 200 without it.
- Reset mid-wait: assert `reset` low during an IN wait -> `in_ready`=0 immediately; `prog_addr`=0; `display`=0. After release, the program restarts from address 0.
